axis_frame_fifo: RTL

- Single-clock, parametrised store-and-forward frame buffer for the Ethernet RX path.
- Sits between the MAC/UDP receive logic and downstream consumers.
- Releases a frame only after its last beat is stored.
- Never back-pressures the source: frames that overflow, or that are flagged bad on their last beat, are dropped whole.
- Keeps byte enables, and reports frame counts and drop events.

---
 rtl/axis_frame_fifo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO for the Ethernet RX path. A frame is released
// only after its last beat is stored; errored or overflowing frames are dropped whole.
module axis_frame_fifo #(
    parameter int  DATA_WIDTH    = 32,
    parameter int  DEPTH         = 256,
    parameter int  DROP_ON_ERROR = 1,
    localparam int KEEP_WIDTH    = DATA_WIDTH / 8,
    localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic [ADDR_WIDTH:0]   stat_frames,
    output logic                  stat_good,
    output logic                  stat_bad,
    output logic                  stat_overflow
);

    localparam int WORD_WIDTH = 1 + KEEP_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } state_t;

    state_t state;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] commit_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] wr_next;
    logic [ADDR_WIDTH:0] used;

    logic                  full;
    logic                  accept;
    logic                  store;
    logic                  frame_bad;
    logic                  commit;
    logic                  load;
    logic                  out_last_hs;
    logic [WORD_WIDTH-1:0] rd_word;

    // Occupancy counts uncommitted beats too, so a frame in progress can itself hit full.
    assign used      = wr_ptr - rd_ptr;
    assign full      = (used == FULL_LEVEL);
    assign wr_next   = wr_ptr + 1'b1;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign store     = accept && (state != DROP) && !full;
    assign frame_bad = s_axis_tuser && (DROP_ON_ERROR != 0);
    assign commit    = store && s_axis_tlast && !frame_bad;

    assign load        = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
    assign out_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign rd_word     = mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge aclk) begin
        if (store) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            s_axis_tready <= 1'b0;
            stat_good     <= 1'b0;
            stat_bad      <= 1'b0;
            stat_overflow <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            stat_good     <= 1'b0;
            stat_bad      <= 1'b0;
            stat_overflow <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE, WRITE: begin
                        if (!full) begin
                            wr_ptr <= wr_next;
                            if (s_axis_tlast) begin
                                state <= IDLE;
                                if (frame_bad) begin
                                    wr_ptr   <= commit_ptr;
                                    stat_bad <= 1'b1;
                                end else begin
                                    commit_ptr <= wr_next;
                                    stat_good  <= 1'b1;
                                end
                            end else begin
                                state <= WRITE;
                            end
                        end else begin
                            // Rewind now; the rest of the frame is swallowed in DROP.
                            wr_ptr <= commit_ptr;
                            if (s_axis_tlast) begin
                                stat_overflow <= 1'b1;
                                state         <= IDLE;
                            end else begin
                                state <= DROP;
                            end
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            stat_overflow <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            rd_ptr        <= rd_ptr + 1'b1;
            m_axis_tvalid <= 1'b1;
            {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_word;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_frames <= '0;
        end else begin
            case ({commit, out_last_hs})
                2'b10:   stat_frames <= stat_frames + 1'b1;
                2'b01:   stat_frames <= stat_frames - 1'b1;
                default: stat_frames <= stat_frames;
            endcase
        end
    end

endmodule
